// File: rtl/sonar_arrival_timer_pkg.sv
// Shared types and default sizes for the sonar arrival timer.
package sonar_arrival_timer_pkg;

    localparam int unsigned SONAR_NUM_CH = 4;
    localparam int unsigned SONAR_CNT_W  = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        COUNT = 3'd2,
        DONE  = 3'd3,
        HOLD  = 3'd4
    } state_t;

endpackage

// File: rtl/sonar_toggle_counter.sv
// Synchronous up-counter built from a chain of enabled toggle cells.
module sonar_toggle_counter
    import sonar_arrival_timer_pkg::*;
#(
    parameter int unsigned CNT_W = SONAR_CNT_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] toggle;

    // Cell k toggles when enabled and every lower bit is already 1.
    assign toggle[0] = enable;
    for (genvar k = 1; k < CNT_W; k++) begin : g_chain
        assign toggle[k] = toggle[k-1] & count[k-1];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            count <= count ^ toggle;
        end
    end

endmodule

// File: rtl/sonar_arrival_timer.sv
// Measures per-channel hydrophone arrival times for one sonar ping and holds
// the results until the navigation interface acknowledges them.
module sonar_arrival_timer
    import sonar_arrival_timer_pkg::*;
#(
    parameter int unsigned NUM_CH  = SONAR_NUM_CH,
    parameter int unsigned CNT_W   = SONAR_CNT_W,
    parameter int unsigned TIMEOUT = 50000,
    parameter int unsigned HOLDOFF = 1000
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    arm,
    input  logic [NUM_CH-1:0]       ch_hit,
    input  logic                    ack,
    output logic                    busy,
    output logic                    done,
    output logic                    timed_out,
    output logic [NUM_CH-1:0]       hit_mask,
    output logic [NUM_CH*CNT_W-1:0] arr_time
);

    localparam int unsigned HO_W = $clog2(HOLDOFF + 1);

    state_t            state;
    logic [NUM_CH-1:0] prev_hit;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] new_mask;
    logic [CNT_W-1:0]  count;
    logic [HO_W-1:0]   holdoff;
    logic              all_hit;
    logic              at_timeout;
    logic              cnt_en;
    logic              cnt_clr;

    sonar_toggle_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk    (clk),
        .resetn (resetn),
        .enable (cnt_en),
        .clear  (cnt_clr),
        .count  (count)
    );

    // Edge detect, capture completion and counter control.
    always_comb begin
        rise       = ch_hit & ~prev_hit;
        new_mask   = hit_mask | rise;
        all_hit    = &new_mask;
        at_timeout = (count == CNT_W'(TIMEOUT));
        cnt_clr    = (state == IDLE) && arm;
        cnt_en     = 1'b0;
        if (state == ARMED) begin
            // Start counting on the first edge so the first COUNT cycle reads 1.
            cnt_en = (|rise) && !all_hit;
        end else if (state == COUNT) begin
            cnt_en = !all_hit && !at_timeout;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            prev_hit  <= '0;
            holdoff   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timed_out <= 1'b0;
            hit_mask  <= '0;
            arr_time  <= '0;
        end else begin
            prev_hit <= ch_hit;
            case (state)
                IDLE: begin
                    if (arm) begin
                        hit_mask  <= '0;
                        arr_time  <= '0;
                        timed_out <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ARMED;
                    end
                end
                ARMED: begin
                    if (|rise) begin
                        for (int unsigned i = 0; i < NUM_CH; i++) begin
                            if (rise[i]) begin
                                arr_time[i*CNT_W +: CNT_W] <= '0;
                            end
                        end
                        hit_mask <= new_mask;
                        if (all_hit) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= COUNT;
                        end
                    end
                end
                COUNT: begin
                    // Only the first edge of each channel is recorded.
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        if (rise[i] && !hit_mask[i]) begin
                            arr_time[i*CNT_W +: CNT_W] <= count;
                        end
                    end
                    hit_mask <= new_mask;
                    if (all_hit) begin
                        done      <= 1'b1;
                        timed_out <= 1'b0;
                        state     <= DONE;
                    end else if (at_timeout) begin
                        done      <= 1'b1;
                        timed_out <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (ack) begin
                        done    <= 1'b0;
                        holdoff <= HO_W'(HOLDOFF);
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    // Ringing-decay window; busy drops when the count reaches 0.
                    holdoff <= holdoff - HO_W'(1);
                    if (holdoff == HO_W'(1)) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
